// File: rtl/digihouse_pkg.sv
// Shared DigiHouse constants, help-call FSM state type and frame byte helper.
package digihouse_pkg;

  localparam logic [7:0] SYNC_BYTE        = 8'hA5;
  localparam logic [7:0] EVT_PANIC        = 8'h01;
  localparam logic [7:0] EVT_PANIC_DANGER = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_DONE,
    ST_FAIL
  } help_state_t;

  // Byte idx of a help-call frame: sync, house, event code, xor checksum.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [7:0] house_id,
                                            input logic [7:0] code);
    case (idx)
      2'd0:    return SYNC_BYTE;
      2'd1:    return house_id;
      2'd2:    return code;
      default: return SYNC_BYTE ^ house_id ^ code;
    endcase
  endfunction

endpackage

// File: rtl/help_call_tx_if.sv
// Controller-side signals of the help-call transmitter.
interface help_call_tx_if;
  logic call_help;
  logic danger_sense;
  logic ack_pulse;
  logic tx;
  logic busy;
  logic call_sent;
  logic call_failed;

  modport master (
    output call_help, danger_sense, ack_pulse,
    input  tx, busy, call_sent, call_failed
  );

  modport slave (
    input  call_help, danger_sense, ack_pulse,
    output tx, busy, call_sent, call_failed
  );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serialiser; done marks the last stop-bit cycle so a new
// start can be accepted on that same cycle with no idle gap.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       busy,
  output logic       done,
  output logic       tx
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;
  logic [3:0]    r_idx;
  logic [8:0]    r_frame;
  logic          r_busy;
  logic          r_tx;
  logic          w_last;

  assign w_last = r_busy && (r_cnt == C_LAST) && (r_idx == 4'd9);
  assign busy   = r_busy;
  assign done   = w_last;
  assign tx     = r_tx;

  // r_idx 0 is the start bit; r_frame[k] is driven while r_idx == k+1.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= '1;
    end else if (start && (!r_busy || w_last)) begin
      r_busy  <= 1'b1;
      r_frame <= {1'b1, data_in};
      r_tx    <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else if (r_busy) begin
      if (r_cnt == C_LAST) begin
        r_cnt <= '0;
        if (r_idx == 4'd9) begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
        end else begin
          r_idx <= r_idx + 4'd1;
          r_tx  <= r_frame[r_idx];
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/help_call_tx.sv
// Emergency help-call sender: frames A5/house/code/checksum over UART,
// waits for an ack and retries a bounded number of times.
module help_call_tx
  import digihouse_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT     = 434,
  parameter logic [7:0]  HOUSE_ID         = 8'h01,
  parameter int unsigned ACK_TIMEOUT_CLKS = 50_000_000,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  help_call_tx_if.slave  bus
);

  localparam int unsigned TO_W = (ACK_TIMEOUT_CLKS > 1) ? $clog2(ACK_TIMEOUT_CLKS) : 1;
  localparam int unsigned RT_W = ($clog2(MAX_RETRIES + 1) > 2) ? $clog2(MAX_RETRIES + 1) : 2;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT_CLKS - 1);
  localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRIES);

  help_state_t     r_state, w_state_nxt;
  logic            r_call_d;
  logic            r_armed;
  logic [7:0]      r_code, w_code_nxt;
  logic [1:0]      r_byte_idx, w_byte_idx_nxt;
  logic [RT_W-1:0] r_retry, w_retry_nxt;
  logic [TO_W-1:0] r_to, w_to_nxt;
  logic            r_drop, w_drop_nxt;

  logic            w_trigger;
  logic            w_start;
  logic [7:0]      w_data;
  logic            w_uart_busy;
  logic            w_uart_done;
  logic            w_uart_tx;

  // r_armed blocks a level already high at reset release from counting as an edge.
  assign w_trigger = bus.call_help && !r_call_d && r_armed && !w_uart_busy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_call_d   <= 1'b0;
      r_armed    <= 1'b0;
      r_code     <= '0;
      r_byte_idx <= '0;
      r_retry    <= '0;
      r_to       <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_call_d   <= bus.call_help;
      r_armed    <= r_armed | ~bus.call_help;
      r_code     <= w_code_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_retry    <= w_retry_nxt;
      r_to       <= w_to_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_start        = 1'b0;
    w_code_nxt     = r_code;
    w_byte_idx_nxt = r_byte_idx;
    w_retry_nxt    = r_retry;
    w_to_nxt       = r_to;
    w_drop_nxt     = r_drop;
    unique case (r_state)
      ST_IDLE: begin
        w_retry_nxt    = '0;
        w_to_nxt       = '0;
        w_byte_idx_nxt = '0;
        w_drop_nxt     = 1'b0;
        if (w_trigger) begin
          w_state_nxt = ST_SEND;
          w_start     = 1'b1;
          w_code_nxt  = bus.danger_sense ? EVT_PANIC_DANGER : EVT_PANIC;
        end
      end
      ST_SEND: begin
        // A cancel seen mid-frame is remembered so the frame still completes.
        if (!bus.call_help) w_drop_nxt = 1'b1;
        if (w_uart_done) begin
          if (r_byte_idx == 2'd3) begin
            w_to_nxt    = '0;
            w_state_nxt = (r_drop || !bus.call_help) ? ST_IDLE : ST_WAIT_ACK;
          end else begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
            w_start        = 1'b1;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (!bus.call_help) begin
          w_state_nxt = ST_IDLE;
        end else if (bus.ack_pulse) begin
          w_state_nxt = ST_DONE;
        end else if (r_to == TO_LAST) begin
          if (r_retry < RT_MAX) begin
            w_retry_nxt    = r_retry + RT_W'(1);
            w_byte_idx_nxt = '0;
            w_start        = 1'b1;
            w_state_nxt    = ST_SEND;
          end else begin
            w_state_nxt = ST_FAIL;
          end
        end else begin
          w_to_nxt = r_to + TO_W'(1);
        end
      end
      ST_DONE, ST_FAIL: begin
        if (!bus.call_help) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_data = frame_byte(w_byte_idx_nxt, HOUSE_ID, w_code_nxt);
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (w_start),
    .data_in(w_data),
    .busy   (w_uart_busy),
    .done   (w_uart_done),
    .tx     (w_uart_tx)
  );

  assign bus.tx          = w_uart_tx;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.call_sent   = (r_state == ST_DONE) && bus.call_help;
  assign bus.call_failed = (r_state == ST_FAIL) && bus.call_help;

endmodule
